ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Provides the transmit direction of the PS/2 link, alongside the existing keyboard receive path.
- Drives clock and data as open-drain enables, and follows the device-generated clock to shift out start, 8 data bits, odd parity and stop.
- Checks the device ACK bit and reports done, ack error or timeout.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 41 ++++
 rtl/ps2_host_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, frame layout,
// common command bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        RELEASE
    } ps2_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PARITY_IDX = 8;
    localparam int unsigned STOP_IDX   = 9;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one PS/2 pin: 2-flop synchroniser, FILT_LEN-sample agreement filter
// and a registered falling-edge strobe of the filtered line.
module ps2_line_filter #(
    parameter int unsigned FILT_LEN = 8
) (
    input  logic clk,
    input  logic ar,
    input  logic pin,
    output logic filt,
    output logic fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] hist;
    logic                filt_nxt;

    // The filtered level only moves once the whole history window agrees.
    always_comb begin
        filt_nxt = filt;
        if (hist == '1) begin
            filt_nxt = 1'b1;
        end else if (hist == '0) begin
            filt_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ar) begin
            sync <= '1;
            hist <= '1;
            filt <= 1'b1;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            hist <= {hist[FILT_LEN-2:0], sync[1]};
            filt <= filt_nxt;
            fall <= filt & ~filt_nxt;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts start/data/parity/stop on device clock falls and checks the ACK bit.
import ps2_pkg::*;

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES   = 5000,
    parameter int unsigned REQ_SETUP_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES   = 750000,
    parameter int unsigned FILT_LEN         = 8
) (
    input  logic                 clk,
    input  logic                 ar,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 ack_err,
    output logic                 timeout_err,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    output logic                 ps2_clk_oe,
    output logic                 ps2_dat_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ?
                                      INHIBIT_CYCLES : REQ_SETUP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [WD_W-1:0]   wdog, wdog_n;
    logic [3:0]        bit_idx, bit_idx_n;
    logic [STOP_IDX:0] shreg, shreg_n;
    logic              dat_oe_q, dat_oe_n;
    logic              ack_q, ack_n;
    logic              to_q, to_n;
    logic              wd_active, wd_expire;

    logic clk_filt, clk_fall;
    logic dat_filt, dat_fall_unused;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk  (clk),
        .ar   (ar),
        .pin  (ps2_clk),
        .filt (clk_filt),
        .fall (clk_fall)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk  (clk),
        .ar   (ar),
        .pin  (ps2_dat),
        .filt (dat_filt),
        .fall (dat_fall_unused)
    );

    always_ff @(posedge clk) begin
        if (ar) begin
            state    <= IDLE;
            cnt      <= '0;
            wdog     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            dat_oe_q <= 1'b0;
            ack_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wdog     <= wdog_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            dat_oe_q <= dat_oe_n;
            ack_q    <= ack_n;
            to_q     <= to_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        wdog_n    = wdog;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        dat_oe_n  = dat_oe_q;
        ack_n     = ack_q;
        to_n      = to_q;
        done      = 1'b0;
        wd_active = (state == SEND) || (state == ACK) || (state == RELEASE);
        wd_expire = wd_active && (wdog == WD_W'(TIMEOUT_CYCLES));

        if (wd_active) begin
            wdog_n = wdog + WD_W'(1);
        end

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_n   = {1'b1, odd_parity(tx_data), tx_data};
                    bit_idx_n = '0;
                    cnt_n     = '0;
                    ack_n     = 1'b0;
                    to_n      = 1'b0;
                    dat_oe_n  = 1'b0;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_n    = '0;
                    dat_oe_n = 1'b1;
                    state_n  = REQ;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            REQ: begin
                if (cnt == CNT_W'(REQ_SETUP_CYCLES - 1)) begin
                    wdog_n  = '0;
                    state_n = SEND;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SEND: begin
                if (clk_fall) begin
                    dat_oe_n  = ~shreg[bit_idx];
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx == 4'(STOP_IDX)) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_n   = dat_filt;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (clk_filt && dat_filt) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Watchdog overrides any same-cycle fall handling.
        if (wd_expire) begin
            state_n  = IDLE;
            dat_oe_n = 1'b0;
            ack_n    = 1'b0;
            to_n     = 1'b1;
            done     = 1'b1;
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe  = dat_oe_q & ~wd_expire;
    assign ack_err     = ack_q & ~wd_expire;
    assign timeout_err = to_q | wd_expire;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain PS/2 device model plus a
// transaction-level reference checked against the DUT every cycle.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH     = 20;
    localparam int REQS    = 4;
    localparam int TMO     = 2000;
    localparam int HALF    = 40;
    localparam int REL_CYC = INH + REQS + 1;

    typedef enum int {M_ACK, M_NACK, M_TMO, M_RST} mode_t;

    logic       clk = 1'b0;
    logic       ar = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, ack_err, timeout_err;
    logic       ps2_clk, ps2_dat, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INH),
        .REQ_SETUP_CYCLES (REQS),
        .TIMEOUT_CYCLES   (TMO),
        .FILT_LEN         (8)
    ) dut (
        .clk         (clk),
        .ar          (ar),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    mode_t cur_mode = M_ACK;
    mode_t m_mode = M_ACK;
    logic  m_init = 1'b0, m_busy = 1'b0, m_ack = 1'b0, m_to = 1'b0;
    logic  seen_done = 1'b0, dev_fin = 1'b0;
    int    m_cyc = 0;
    int    m_accepts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected on-wire frame {stop, parity, data}, parity chosen so ones are odd.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Transaction-level reference: idle/busy, cycles since acceptance, sticky flags.
    always @(posedge clk) begin
        if (ar) begin
            m_init <= 1'b1;
            m_busy <= 1'b0;
            m_cyc  <= 0;
            m_ack  <= 1'b0;
            m_to   <= 1'b0;
        end else if (m_busy) begin
            if (seen_done) begin
                m_busy <= 1'b0;
                m_ack  <= (m_mode == M_NACK);
                m_to   <= (m_mode == M_TMO);
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end else if (tx_valid) begin
            m_busy    <= 1'b1;
            m_cyc     <= 1;
            m_ack     <= 1'b0;
            m_to      <= 1'b0;
            m_mode    <= cur_mode;
            m_accepts <= m_accepts + 1;
        end
    end

    always @(negedge clk) begin
        seen_done <= m_busy && done;
        if (m_init) begin
            chk("tx_ready", tx_ready, !m_busy);
            chk("busy", busy, m_busy);
            if (!m_busy) begin
                chk("idle_done", done, 1'b0);
                chk("idle_clk_oe", ps2_clk_oe, 1'b0);
                chk("idle_dat_oe", ps2_dat_oe, 1'b0);
                chk("idle_ack_err", ack_err, m_ack);
                chk("idle_timeout_err", timeout_err, m_to);
            end else begin
                if (m_cyc <= INH) begin
                    chk("inhibit_clk_oe", ps2_clk_oe, 1'b1);
                    chk("inhibit_dat_oe", ps2_dat_oe, 1'b0);
                end else if (m_cyc < REL_CYC) begin
                    chk("req_clk_oe", ps2_clk_oe, 1'b1);
                    chk("req_dat_oe", ps2_dat_oe, 1'b1);
                end else begin
                    chk("released_clk_oe", ps2_clk_oe, 1'b0);
                end
                if (m_mode == M_RST) begin
                    chk("abort_no_done", done, 1'b0);
                end else if (done) begin
                    chk("done_dat_oe", ps2_dat_oe, 1'b0);
                    chk("done_ack_err", ack_err, (m_mode == M_NACK));
                    chk("done_timeout_err", timeout_err, (m_mode == M_TMO));
                    if (m_mode == M_TMO) chk("timeout_cycle", m_cyc, REL_CYC + TMO);
                    else chk("done_after_device", dev_fin, 1'b1);
                end else if (m_mode == M_TMO && m_cyc >= REL_CYC + TMO) begin
                    chk("timeout_fired", done, 1'b1);
                end
            end
        end
    end

    // Device: wait for request-to-send, clock n_pulses frames bits, sample on rises.
    task automatic device(input int n_pulses, input bit give_ack, input bit glitch,
                          output logic [9:0] cap);
        int w;
        cap     = '0;
        dev_fin = 1'b0;
        w       = 0;
        while (!(busy === 1'b1 && ps2_clk_oe === 1'b0 && ps2_dat === 1'b0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("dev_request_seen", (w < 400), 1'b1);
        if (w >= 400) return;
        tick(30);
        for (int p = 1; p <= n_pulses; p++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (p <= 10) cap[p-1] = ps2_dat;
            if (p == 11) begin
                dev_dat_low = 1'b0;
                dev_fin     = 1'b1;
            end
            if (glitch && p == 3) begin
                tick(10);
                dev_clk_low = 1'b1;
                tick(5);
                dev_clk_low = 1'b0;
                tick(HALF - 15);
            end else if (give_ack && p == 10) begin
                tick(5);
                dev_dat_low = 1'b1;
                tick(HALF - 5);
            end else begin
                tick(HALF);
            end
        end
    endtask

    task automatic wait_accept(input int target);
        int w;
        w = 0;
        while (m_accepts < target && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_within_budget", (m_accepts >= target), 1'b1);
    endtask

    task automatic start_tx(input logic [7:0] d, input mode_t md);
        int a0;
        a0       = m_accepts;
        tx_data  = d;
        cur_mode = md;
        tx_valid = 1'b1;
        wait_accept(a0 + 1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("done_within_budget", (w < budget), 1'b1);
    endtask

    initial begin
        logic [9:0] cap;
        logic [7:0] d;
        bit         nack, gl;
        int         a0;

        tick(3);
        ar = 1'b0;
        tick(2);
        @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_dat_oe", ps2_dat_oe, 1'b0);
        chk("rst_flags", {done, ack_err, timeout_err}, 3'b000);

        // Reset after four data falls: lines released next cycle, no done.
        start_tx(8'h5A, M_RST);
        device(4, 1'b0, 1'b0, cap);
        ar = 1'b1;
        tick(1);
        ar = 1'b0;
        chk("abort_clk_oe", ps2_clk_oe, 1'b0);
        chk("abort_dat_oe", ps2_dat_oe, 1'b0);
        chk("abort_tx_ready", tx_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        repeat (300) @(negedge clk);

        start_tx(CMD_SET_LEDS, M_ACK);
        device(11, 1'b1, 1'b0, cap);
        chk("frame_ED", cap, 10'h3ED);
        wait_idle(300);
        chk("ED_ack_err", ack_err, 1'b0);
        chk("ED_timeout_err", timeout_err, 1'b0);

        start_tx(8'h00, M_NACK);
        device(11, 1'b0, 1'b0, cap);
        chk("frame_00", cap, 10'h300);
        wait_idle(300);
        chk("00_ack_err", ack_err, 1'b1);

        start_tx(CMD_RESET, M_TMO);
        wait_idle(REL_CYC + TMO + 200);
        chk("FF_timeout_err", timeout_err, 1'b1);
        chk("FF_ack_err", ack_err, 1'b0);

        // tx_valid held through a glitched frame; second byte queued behind done.
        a0       = m_accepts;
        tx_data  = CMD_ECHO;
        cur_mode = M_ACK;
        tx_valid = 1'b1;
        wait_accept(a0 + 1);
        tx_data  = 8'h3C;
        cur_mode = M_NACK;
        device(11, 1'b1, 1'b1, cap);
        chk("frame_EE_glitch", cap, 10'h3EE);
        wait_accept(a0 + 2);
        tx_valid = 1'b0;
        device(11, 1'b0, 1'b0, cap);
        chk("frame_3C", cap, exp_frame(8'h3C));
        wait_idle(300);
        chk("3C_ack_err", ack_err, 1'b1);

        for (int i = 0; i < 5; i++) begin
            d    = 8'($urandom);
            nack = 1'($urandom_range(0, 1));
            gl   = 1'($urandom_range(0, 1));
            start_tx(d, nack ? M_NACK : M_ACK);
            device(11, !nack, gl, cap);
            chk("rand_frame", cap, exp_frame(d));
            wait_idle(300);
            chk("rand_ack_err", ack_err, nack);
        end

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
